bus_arbiter: RTL and testbench

- Shares the single APB-style system bus (addr/select/enable/write/wdata/rdata/ready) between MasterCount bus masters.
- Masters are bus access units, e.g. the core's cache/IO bus unit and a debug or DMA master.
- Each master sees a private APB-style port. The arbiter grants requests round-robin, replays the granted request on the shared bus with its own setup/access phases, and routes ready/rdata back to the owner.
- Sits between the masters and the shared-bus interconnect.

---
 rtl/bus_arbiter.sv | 157 +++++++++++++++
 tb/tb_bus_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one APB-style bus among MasterCount private master ports.
// Optional BUS_ARBITER_LOCK_EN adds mLock for back-to-back locked bursts by one master.

module bus_arbiter #(
  parameter int unsigned MasterCount = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [MasterCount-1:0][31:0]         mAddr,
  input  logic [MasterCount-1:0]               mSelect,
  input  logic [MasterCount-1:0]               mEnable,
  input  logic [MasterCount-1:0]               mWrite,
  input  logic [MasterCount-1:0][31:0]         mWdata,
`ifdef BUS_ARBITER_LOCK_EN
  input  logic [MasterCount-1:0]               mLock,
`endif
  output logic [MasterCount-1:0][31:0]         mRdata,
  output logic [MasterCount-1:0]               mReady,
  output logic [31:0]                          addr,
  output logic                                 select,
  output logic                                 enable,
  output logic                                 write,
  output logic [31:0]                          wdata,
  input  logic [31:0]                          rdata,
  input  logic                                 ready,
  output logic [$clog2(MasterCount)-1:0]       owner
);

  localparam int unsigned OwnerW = $clog2(MasterCount);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StSetup  = 2'd1;
  localparam logic [1:0] StAccess = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [OwnerW-1:0] owner_q, owner_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              write_q, write_d;

  logic [MasterCount-1:0] req;
  logic [OwnerW-1:0]      winner;
  logic [OwnerW-1:0]      cand;
  logic                   found;

`ifdef BUS_ARBITER_LOCK_EN
  logic lock_q, lock_d;
`endif

  assign req = mSelect & mEnable;

  // Search starts one past the last owner and wraps, so every requester is reached.
  always_comb begin
    found  = 1'b0;
    winner = owner_q;
    cand   = owner_q;
    for (int unsigned k = 0; k < MasterCount; k++) begin
      cand = (cand == OwnerW'(MasterCount - 1)) ? '0 : cand + OwnerW'(1);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
`ifdef BUS_ARBITER_LOCK_EN
    // While locked only the owner may be re-granted; a dropped mLock frees arbitration now.
    if (lock_q && mLock[owner_q]) begin
      found  = req[owner_q];
      winner = owner_q;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
`ifdef BUS_ARBITER_LOCK_EN
    lock_d  = lock_q;
`endif
    case (state_q)
      StIdle: begin
`ifdef BUS_ARBITER_LOCK_EN
        lock_d = lock_q && mLock[owner_q];
`endif
        if (found) begin
          owner_d = winner;
          addr_d  = mAddr[winner];
          wdata_d = mWdata[winner];
          write_d = mWrite[winner];
          state_d = StSetup;
        end
      end
      StSetup: begin
        state_d = StAccess;
      end
      StAccess: begin
        if (ready) begin
          state_d = StIdle;
`ifdef BUS_ARBITER_LOCK_EN
          lock_d  = lock_q || mLock[owner_q];
`endif
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      owner_q <= OwnerW'(MasterCount - 1);
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
`ifdef BUS_ARBITER_LOCK_EN
      lock_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
`ifdef BUS_ARBITER_LOCK_EN
      lock_q  <= lock_d;
`endif
    end
  end

  logic bus_active;
  logic in_access;

  assign bus_active = (state_q == StSetup) || (state_q == StAccess);
  assign in_access  = (state_q == StAccess);

  always_comb begin
    select = bus_active;
    enable = in_access;
    addr   = bus_active ? addr_q : '0;
    wdata  = bus_active ? wdata_q : '0;
    write  = bus_active && write_q;
    owner  = owner_q;
  end

  // A reset arriving in the completing cycle must not leak a ready pulse.
  always_comb begin
    for (int unsigned i = 0; i < MasterCount; i++) begin
      mRdata[i] = rdata;
      mReady[i] = in_access && ready && !rst && (owner_q == OwnerW'(i));
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with a transaction scoreboard popped on each mReady pulse.
// Define BUS_ARBITER_LOCK_EN for both files to also exercise the locked-burst path.

module tb_bus_arbiter;

  localparam int unsigned MC = 2;

  logic                 clk;
  logic                 rst;
  logic [MC-1:0][31:0]  mAddr;
  logic [MC-1:0]        mSelect;
  logic [MC-1:0]        mEnable;
  logic [MC-1:0]        mWrite;
  logic [MC-1:0][31:0]  mWdata;
  logic [MC-1:0][31:0]  mRdata;
  logic [MC-1:0]        mReady;
  logic [31:0]          addr;
  logic                 select;
  logic                 enable;
  logic                 write;
  logic [31:0]          wdata;
  logic [31:0]          rdata;
  logic                 ready;
  logic [$clog2(MC)-1:0] owner;
`ifdef BUS_ARBITER_LOCK_EN
  logic [MC-1:0]        mLock;
`endif

  int checks;
  int failures;

  typedef struct {
    int unsigned own;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;

  txn_t sb_q[$];

  bus_arbiter #(.MasterCount(MC)) dut (
    .clk     (clk),
    .rst     (rst),
    .mAddr   (mAddr),
    .mSelect (mSelect),
    .mEnable (mEnable),
    .mWrite  (mWrite),
    .mWdata  (mWdata),
`ifdef BUS_ARBITER_LOCK_EN
    .mLock   (mLock),
`endif
    .mRdata  (mRdata),
    .mReady  (mReady),
    .addr    (addr),
    .select  (select),
    .enable  (enable),
    .write   (write),
    .wdata   (wdata),
    .rdata   (rdata),
    .ready   (ready),
    .owner   (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic push(input int unsigned o, input logic [31:0] a, input logic w,
                      input logic [31:0] d, input logic [31:0] r);
    txn_t e;
    e.own = o; e.addr = a; e.wr = w; e.wdata = d; e.rdata = r;
    sb_q.push_back(e);
  endtask

  task automatic drive(input int unsigned m, input logic [31:0] a, input logic w,
                       input logic [31:0] d);
    mSelect[m] = 1'b1;
    mEnable[m] = 1'b1;
    mAddr[m]   = a;
    mWrite[m]  = w;
    mWdata[m]  = d;
  endtask

  task automatic release_master(input int unsigned m);
    mSelect[m] = 1'b0;
    mEnable[m] = 1'b0;
  endtask

  // Called in a cycle where a completion is expected; compares against the oldest entry.
  task automatic sb_check(input string tag);
    txn_t e;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_underflow"}, 32'(mReady), 32'd0);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_mready"}, 32'(mReady), 32'd1 << e.own);
      chk({tag, "_owner"},  32'(owner), e.own);
      chk({tag, "_addr"},   addr, e.addr);
      chk({tag, "_write"},  32'(write), 32'(e.wr));
      chk({tag, "_wdata"},  wdata, e.wr ? e.wdata : 32'd0);
      chk({tag, "_rdata"},  mRdata[e.own], e.rdata);
      chk({tag, "_enable"}, 32'(enable), 32'd1);
    end
  endtask

  task automatic run_to_ready(input string tag, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      settle();
      if (mReady != '0) seen = 1'b1;
    end
    if (seen) sb_check(tag);
    else chk({tag, "_timeout"}, 32'(mReady), 32'hFFFF_FFFF);
  endtask

  task automatic reset_dut();
    tick();
    rst = 1'b1;
    mSelect = '0; mEnable = '0; mWrite = '0; mAddr = '0; mWdata = '0;
    ready = 1'b0; rdata = '0;
`ifdef BUS_ARBITER_LOCK_EN
    mLock = '0;
`endif
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;

    // Reset state
    reset_dut();
    rdata = 32'h1234_5678;
    settle();
    chk("rst_select", 32'(select), 32'd0);
    chk("rst_enable", 32'(enable), 32'd0);
    chk("rst_write",  32'(write), 32'd0);
    chk("rst_addr",   addr, 32'd0);
    chk("rst_wdata",  wdata, 32'd0);
    chk("rst_mready", 32'(mReady), 32'd0);
    chk("rst_owner",  32'(owner), MC - 1);
    chk("rst_rdata_bcast", mRdata[1], 32'h1234_5678);

    // Single master read, zero-wait slave
    tick();
    drive(0, 32'h0000_1000, 1'b0, 32'h0);
    ready = 1'b1;
    rdata = 32'hDEAD_BEEF;
    push(0, 32'h0000_1000, 1'b0, 32'h0, 32'hDEAD_BEEF);
    settle();
    chk("rd_t0_select", 32'(select), 32'd0);
    tick();
    settle();
    chk("rd_t1_select", 32'(select), 32'd1);
    chk("rd_t1_enable", 32'(enable), 32'd0);
    chk("rd_t1_addr",   addr, 32'h0000_1000);
    chk("rd_t1_mready", 32'(mReady), 32'd0);
    tick();
    settle();
    sb_check("rd_t2");
    release_master(0);
    tick();
    settle();
    chk("rd_gap_select", 32'(select), 32'd0);
    chk("rd_gap_mready", 32'(mReady), 32'd0);

    // Contention after reset: continuous requests alternate 0,1,0,1
    reset_dut();
    ready = 1'b1;
    rdata = 32'hC0FF_EE00;
    drive(0, 32'h0000_0A00, 1'b0, 32'h0);
    drive(1, 32'h0000_0B00, 1'b0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) push(0, 32'h0000_0A00, 1'b0, 32'h0, 32'hC0FF_EE00);
      else push(1, 32'h0000_0B00, 1'b0, 32'h0, 32'hC0FF_EE00);
    end
    for (int k = 0; k < 4; k++) begin
      run_to_ready($sformatf("rr%0d", k), 6);
      if (k == 3) begin
        release_master(0);
        release_master(1);
      end
      tick();
      settle();
      chk($sformatf("rr%0d_gap_select", k), 32'(select), 32'd0);
    end

    // Master 1 write, three wait states
    ready = 1'b0;
    rdata = 32'h0;
    drive(1, 32'h0000_2004, 1'b1, 32'h0000_55AA);
    push(1, 32'h0000_2004, 1'b1, 32'h0000_55AA, 32'h0);
    tick();
    settle();
    chk("wr_setup_enable", 32'(enable), 32'd0);
    chk("wr_setup_write",  32'(write), 32'd1);
    chk("wr_setup_wdata",  wdata, 32'h0000_55AA);
    chk("wr_setup_addr",   addr, 32'h0000_2004);
    for (int i = 0; i < 3; i++) begin
      tick();
      settle();
      chk($sformatf("wr_wait%0d_enable", i), 32'(enable), 32'd1);
      chk($sformatf("wr_wait%0d_mready", i), 32'(mReady), 32'd0);
      chk($sformatf("wr_wait%0d_write", i),  32'(write), 32'd1);
    end
    tick();
    ready = 1'b1;
    settle();
    sb_check("wr_done");
    release_master(1);

    // Master 0 withdraws during Setup; latched request still completes once
    tick();
    ready = 1'b0;
    drive(0, 32'h0000_3000, 1'b1, 32'hA5A5_A5A5);
    push(0, 32'h0000_3000, 1'b1, 32'hA5A5_A5A5, 32'h0);
    tick();
    release_master(0);
    mAddr[0]  = 32'hFFFF_FFFF;
    mWdata[0] = 32'h0;
    settle();
    chk("wd_setup_select", 32'(select), 32'd1);
    chk("wd_setup_addr",   addr, 32'h0000_3000);
    tick();
    ready = 1'b1;
    settle();
    sb_check("wd_done");
    tick();
    settle();
    chk("wd_single_pulse", 32'(mReady), 32'd0);
    chk("wd_idle_select",  32'(select), 32'd0);
    drive(1, 32'h0000_4000, 1'b0, 32'h0);
    push(1, 32'h0000_4000, 1'b0, 32'h0, 32'h0);
    run_to_ready("wd_next", 6);
    release_master(1);

    // Reset while stalled in Access
    tick();
    ready = 1'b0;
    drive(0, 32'h0000_5000, 1'b0, 32'h0);
    tick();
    tick();
    settle();
    chk("ra_access_enable", 32'(enable), 32'd1);
    rst = 1'b1;
    settle();
    chk("ra_rst_mready", 32'(mReady), 32'd0);
    tick();
    settle();
    chk("ra_after_select", 32'(select), 32'd0);
    chk("ra_after_enable", 32'(enable), 32'd0);
    chk("ra_after_owner",  32'(owner), MC - 1);
    chk("ra_after_mready", 32'(mReady), 32'd0);
    rst = 1'b0;
    release_master(0);
    ready = 1'b1;
    tick();
    settle();
    chk("ra_idle_mready", 32'(mReady), 32'd0);

`ifdef BUS_ARBITER_LOCK_EN
    // Locked 4-word burst by master 0 while master 1 requests continuously
    reset_dut();
    ready = 1'b1;
    rdata = 32'h1111_2222;
    mLock[0] = 1'b1;
    drive(0, 32'h0000_8000, 1'b0, 32'h0);
    drive(1, 32'h0000_9000, 1'b0, 32'h0);
    for (int w = 0; w < 4; w++) push(0, 32'h0000_8000 + 32'(4 * w), 1'b0, 32'h0, 32'h1111_2222);
    push(1, 32'h0000_9000, 1'b0, 32'h0, 32'h1111_2222);
    for (int w = 0; w < 4; w++) begin
      run_to_ready($sformatf("lk%0d", w), 6);
      mAddr[0] = 32'h0000_8000 + 32'(4 * (w + 1));
    end
    mLock[0] = 1'b0;
    release_master(0);
    run_to_ready("lk_release", 8);
    release_master(1);
`endif

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
